// File: rtl/jump_judge.sv
// Jump game judge: captures a charged press, animates the jump offset on tick,
// and scores the landing against the target distance or latches a game-over.
module jump_judge #(
   parameter int W         = 4,
   parameter int TOL       = 1,
   parameter int EXACT_PTS = 2,
   parameter int NEAR_PTS  = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tick,
   input  logic         is_pressing,
   input  logic [W-1:0] press_time,
   input  logic [W-1:0] target_dist,
   output logic [W-1:0] jump_pos,
   output logic         in_flight,
   output logic         score_signal,
   output logic [3:0]   get_score,
   output logic         next_target,
   output logic         game_end
);

   typedef enum logic [2:0] {
      IDLE,
      CHARGE,
      FLIGHT,
      JUDGE,
      OVER
   } state_t;

   state_t       state;
   state_t       state_nx;
   logic         prev_press;
   logic [W-1:0] dist_r;
   logic [W-1:0] tgt_r;
   logic         release_ev;
   logic [W:0]   dist_x;
   logic [W:0]   tgt_x;
   logic [W:0]   diff;

   assign release_ev = prev_press & ~is_pressing;

   // One extra bit keeps the absolute difference from wrapping.
   assign dist_x = {1'b0, dist_r};
   assign tgt_x  = {1'b0, tgt_r};
   assign diff   = (dist_x >= tgt_x) ? (dist_x - tgt_x) : (tgt_x - dist_x);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_press <= 1'b0;
         dist_r     <= '0;
         tgt_r      <= '0;
         jump_pos   <= '0;
      end else begin
         prev_press <= is_pressing;
         case (state)
            CHARGE: begin
               // Capture wins over a coincident tick, so the jump starts at 0.
               if (release_ev) begin
                  dist_r   <= press_time;
                  tgt_r    <= target_dist;
                  jump_pos <= '0;
               end
            end
            FLIGHT: begin
               if (tick && (jump_pos != dist_r)) begin
                  jump_pos <= jump_pos + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx     = state;
      in_flight    = 1'b0;
      score_signal = 1'b0;
      next_target  = 1'b0;
      get_score    = '0;
      game_end     = 1'b0;
      case (state)
         IDLE: begin
            if (is_pressing) state_nx = CHARGE;
         end
         CHARGE: begin
            if (release_ev) state_nx = FLIGHT;
         end
         FLIGHT: begin
            in_flight = 1'b1;
            if (jump_pos == dist_r) state_nx = JUDGE;
         end
         JUDGE: begin
            if (int'(diff) <= TOL) begin
               score_signal = 1'b1;
               next_target  = 1'b1;
               get_score    = (diff == '0) ? 4'(EXACT_PTS) : 4'(NEAR_PTS);
               state_nx     = IDLE;
            end else begin
               state_nx = OVER;
            end
         end
         OVER: begin
            game_end = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_jump_judge.sv
// Scoreboarded bench for jump_judge: landings are predicted at release time and
// matched against score/game-over events observed on the falling clock edge.
module tb_jump_judge;

   localparam int W         = 4;
   localparam int TOL       = 1;
   localparam int EXACT_PTS = 2;
   localparam int NEAR_PTS  = 1;

   typedef struct {
      bit       miss;
      bit [3:0] pts;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         tick = 1'b0;
   logic         is_pressing = 1'b0;
   logic [W-1:0] press_time = '0;
   logic [W-1:0] target_dist = '0;
   logic [W-1:0] jump_pos;
   logic         in_flight;
   logic         score_signal;
   logic [3:0]   get_score;
   logic         next_target;
   logic         game_end;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   bit   ge_prev = 1'b0;

   jump_judge #(.W(W), .TOL(TOL), .EXACT_PTS(EXACT_PTS), .NEAR_PTS(NEAR_PTS)) dut (
      .clk(clk), .rst(rst), .tick(tick), .is_pressing(is_pressing),
      .press_time(press_time), .target_dist(target_dist), .jump_pos(jump_pos),
      .in_flight(in_flight), .score_signal(score_signal), .get_score(get_score),
      .next_target(next_target), .game_end(game_end)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input int pt, input int td);
      exp_t e;
      int   d;
      d      = (pt > td) ? pt - td : td - pt;
      e.miss = (d > TOL);
      e.pts  = e.miss ? 4'd0 : ((d == 0) ? 4'(EXACT_PTS) : 4'(NEAR_PTS));
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: every landing or miss event must match a prediction.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         ge_prev = 1'b0;
      end else begin
         if (score_signal || (game_end && !ge_prev)) begin
            if (sb.size() == 0) begin
               check("unexpected_event", 1, 0);
            end else begin
               e = sb.pop_front();
               check("ev_miss", game_end, e.miss);
               check("ev_next_target", next_target, !e.miss);
               if (!e.miss) check("ev_pts", get_score, e.pts);
            end
         end
         ge_prev = game_end;
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_jump_pos"}, jump_pos, 0);
      check({tag, "_in_flight"}, in_flight, 0);
      check({tag, "_score"}, score_signal, 0);
      check({tag, "_get_score"}, get_score, 0);
      check({tag, "_next_target"}, next_target, 0);
      check({tag, "_game_end"}, game_end, 0);
   endtask

   // Asynchronous reset asserted mid-cycle, checked before the next edge.
   task automatic apply_reset(input string tag);
      #2 rst = 1'b0;
      #1 check_all_zero(tag);
      sb.delete();
      step();
      rst = 1'b1;
   endtask

   task automatic press_release(input int pt, input int td, input bit rtick);
      is_pressing = 1'b1;
      step();
      step();
      press_time  = W'(pt);
      target_dist = W'(td);
      is_pressing = 1'b0;
      tick        = rtick;
   endtask

   task automatic jump(input int pt, input int td, input bit hold, input bit rtick);
      exp_t e;
      e = model(pt, td);
      press_release(pt, td, rtick);
      sb.push_back(e);
      step();
      tick        = 1'b0;
      target_dist = W'(15 - td);
      check("rel_in_flight", in_flight, 1);
      check("rel_jump_pos", jump_pos, 0);
      if (hold) is_pressing = 1'b1;
      if (pt > 0) begin
         step();
         check("notick_hold", jump_pos, 0);
      end
      for (int i = 1; i <= pt; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         check("tick_pos", jump_pos, i);
         check("tick_in_flight", in_flight, 1);
      end
      is_pressing = 1'b0;
      step();
      check("judge_in_flight", in_flight, 0);
      check("judge_score", score_signal, !e.miss);
      check("judge_get_score", get_score, e.pts);
      step();
      check("post_score", score_signal, 0);
      check("post_game_end", game_end, e.miss);
      check("post_jump_pos", jump_pos, pt);
   endtask

   initial begin
      #2 check_all_zero("reset");
      step();
      rst = 1'b1;
      step();

      jump(5, 5, 1'b0, 1'b0);
      jump(6, 5, 1'b0, 1'b0);
      jump(3, 5, 1'b0, 1'b0);

      // Game over: further presses and ticks are ignored.
      press_release(4, 4, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step();
         tick = 1'b1;
      end
      tick = 1'b0;
      check("over_jump_pos", jump_pos, 3);
      check("over_in_flight", in_flight, 0);
      check("over_game_end", game_end, 1);
      apply_reset("rst_over");
      step();

      jump(0, 1, 1'b0, 1'b0);
      jump(4, 4, 1'b1, 1'b1);
      jump(15, 0, 1'b0, 1'b0);
      apply_reset("rst_over2");
      step();

      // Reset in the middle of a jump abandons it.
      press_release(5, 5, 1'b0);
      sb.push_back(model(5, 5));
      step();
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1;
         step();
      end
      tick = 1'b0;
      check("mid_jump_pos", jump_pos, 3);
      is_pressing = 1'b1;
      apply_reset("rst_flight");
      for (int i = 0; i < 4; i++) step();
      check("no_stale_pulse", score_signal, 0);

      // Button still held across reset deassert starts a fresh charge.
      press_time  = 4'd2;
      target_dist = 4'd3;
      sb.push_back(model(2, 3));
      is_pressing = 1'b0;
      step();
      check("held_in_flight", in_flight, 1);
      tick = 1'b1;
      step();
      step();
      tick = 1'b0;
      check("held_jump_pos", jump_pos, 2);
      step();
      check("held_score", score_signal, 1);
      check("held_get_score", get_score, NEAR_PTS);
      step();
      step();

      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/jump_judge.md
JUMP_JUDGE -- requirements
Module: jump_judge

Interface
REQ-001 The module SHALL have parameter W, default 4, the width of press_time, target_dist and jump_pos.
REQ-002 The module SHALL have parameter TOL, default 1, the maximum |press_time - target_dist| still counted as a landing.
REQ-003 The module SHALL have parameter EXACT_PTS, default 2, the points awarded when press_time equals target_dist.
REQ-004 The module SHALL have parameter NEAR_PTS, default 1, the points awarded on a non-exact landing.
REQ-005 Port clk, input, 1 bit: single clock for all state.
REQ-006 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port tick, input, 1 bit: animation step enable, one clk wide, derived from the clock divider.
REQ-008 Port is_pressing, input, 1 bit: debounced button level, 1 while held.
REQ-009 Port press_time, input, W bits: charge count from the press-time producer, stable on the release cycle.
REQ-010 Port target_dist, input, W bits: distance to the next platform.
REQ-011 Port jump_pos, output, W bits: current jump offset for VGA drawing.
REQ-012 Port in_flight, output, 1 bit: high while the jump is animating.
REQ-013 Port score_signal, output, 1 bit: one-clk pulse on a successful landing.
REQ-014 Port get_score, output, 4 bits: points for the landing, valid while score_signal is high.
REQ-015 Port next_target, output, 1 bit: one-clk pulse requesting a new platform, coincident with score_signal.
REQ-016 Port game_end, output, 1 bit: sticky miss flag.

Function
REQ-017 The FSM SHALL have states IDLE, CHARGE, FLIGHT, JUDGE and OVER.
REQ-018 is_pressing SHALL be registered each clk as prev_press; release means prev_press=1 and is_pressing=0.
REQ-019 IDLE SHALL go to CHARGE when is_pressing=1.
REQ-020 On release in CHARGE, the module SHALL capture press_time into dist_r and target_dist into tgt_r, clear jump_pos to 0, and enter FLIGHT.
REQ-021 In FLIGHT, on each tick with jump_pos<dist_r, jump_pos SHALL increment by 1.
REQ-022 In FLIGHT, the first clk with jump_pos==dist_r SHALL move the FSM to JUDGE; dist_r=0 SHALL therefore reach JUDGE one clk after entry with no tick needed.
REQ-023 in_flight SHALL be 1 exactly while the state is FLIGHT.
REQ-024 JUDGE SHALL last one clk and compute diff = |dist_r - tgt_r| unsigned, using W+1-bit arithmetic with no wrap.
REQ-025 If diff==0, JUDGE SHALL pulse score_signal and next_target with get_score=EXACT_PTS, then go to IDLE.
REQ-026 If 0<diff<=TOL, JUDGE SHALL pulse score_signal and next_target with get_score=NEAR_PTS, then go to IDLE.
REQ-027 If diff>TOL, JUDGE SHALL set game_end=1 and go to OVER with no score pulse.
REQ-028 OVER SHALL be absorbing: all inputs are ignored, game_end stays 1 and jump_pos holds; only rst exits.
REQ-029 is_pressing in FLIGHT or JUDGE SHALL be ignored, with no restart and no capture.
REQ-030 If the button is still held when the FSM returns to IDLE, a new CHARGE SHALL start on the next clk.
REQ-031 get_score SHALL be 0 whenever score_signal=0.
REQ-032 jump_pos SHALL hold its last value in IDLE until the next capture.
REQ-033 tick coinciding with the release cycle SHALL NOT advance jump_pos, because the capture takes precedence.
REQ-034 Changes on target_dist after capture SHALL NOT affect the current judgement.

Reset
REQ-035 rst=0 SHALL asynchronously force state=IDLE and clear jump_pos, dist_r, tgt_r and prev_press to 0.
REQ-036 rst=0 SHALL asynchronously force in_flight, score_signal, next_target and game_end to 0 and get_score to 0.
REQ-037 Reset asserted mid-FLIGHT or in OVER SHALL abandon the jump with no pulse emitted.
REQ-038 After rst deasserts, the block SHALL wait for a fresh press; a button already held at deassert SHALL enter CHARGE.

Verification
REQ-039 Bench SHALL cover: press, release with press_time=5, target_dist=5, 5 ticks -> jump_pos steps 0..5, in_flight high, then one-clk score_signal with get_score=2 and next_target=1.
REQ-040 Bench SHALL cover: press_time=6, target_dist=5 -> get_score=1 pulse; then press_time=3, target_dist=5 -> game_end=1, no pulse, later presses ignored.
REQ-041 Bench SHALL cover: press_time=0, target_dist=1 -> JUDGE two clks after release with no ticks, get_score=1.
REQ-042 Bench SHALL cover: press_time=15, target_dist=0 -> diff=15 with no wrap, game_end=1.
REQ-043 Bench SHALL cover: press during FLIGHT, and tick on the release cycle -> no restart; jump_pos advances only on later ticks.
REQ-044 Bench SHALL cover: rst low mid-FLIGHT at jump_pos=3, and rst low in OVER -> all outputs 0 immediately (asynchronous), state IDLE.
